// File: rtl/gray_count_sequencer.sv
// gray_count_sequencer: command-driven up/down counter sequencer with a registered Gray-code copy of the count.
module gray_count_sequencer #(
  parameter int MOD_VALUE = 8,
  localparam int W = $clog2(MOD_VALUE)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_dir,
  input  logic [W-1:0] cmd_steps,
  input  logic         pause,
  input  logic         abort,
  output logic [W-1:0] count_binary,
  output logic [W-1:0] gray_count_out,
  output logic         busy,
  output logic         done,
  output logic         wrap
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d, gray_q, gray_d, rem_q, rem_d;
  logic dir_q, dir_d, wrap_q, wrap_d, step;
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    dir_d = dir_q;
    step = 1'b0;
    if (state_q == IDLE) begin
      if (cmd_valid) begin
        dir_d = cmd_dir;
        rem_d = cmd_steps;
        state_d = cmd_steps != '0 ? RUN : DONE;
      end
    end else if (state_q == RUN) begin
      if (abort) begin
        state_d = IDLE;
        rem_d = '0;
      end else if (!pause) begin
        step = 1'b1;
        rem_d = rem_q - 1'b1;
        state_d = rem_q == W'(1) ? DONE : RUN;
      end
    end else begin
      state_d = IDLE;
    end
    cnt_d = step ? (dir_q ? cnt_q + 1'b1 : cnt_q - 1'b1) : cnt_q;
    wrap_d = step & (dir_q ? &cnt_q : ~|cnt_q);
    // Gray is derived from the next count so both registers update on the same edge.
    gray_d = cnt_d ^ (cnt_d >> 1);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      gray_q <= '0;
      rem_q <= '0;
      dir_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      gray_q <= gray_d;
      rem_q <= rem_d;
      dir_q <= dir_d;
      wrap_q <= wrap_d;
    end
  end
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign wrap = wrap_q;
  assign count_binary = cnt_q;
  assign gray_count_out = gray_q;
endmodule

// File: tb/tb_gray_count_sequencer.sv
// tb_gray_count_sequencer: scoreboard bench; the driver predicts each count update and done pulse, a monitor checks them.
module tb_gray_count_sequencer;
  localparam int MOD = 8;
  localparam int W = 3;
  logic clk = 0, rst = 1, cmd_valid = 0, cmd_dir = 0, pause = 0, abort = 0;
  logic [W-1:0] cmd_steps = '0;
  logic cmd_ready, busy, done, wrap;
  logic [W-1:0] count_binary, gray_count_out;
  gray_count_sequencer #(.MOD_VALUE(MOD)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .pause(pause), .abort(abort),
    .count_binary(count_binary), .gray_count_out(gray_count_out),
    .busy(busy), .done(done), .wrap(wrap)
  );
  typedef struct {int c; bit w; int t;} exp_t;
  exp_t exp_q[$];
  int done_q[$];
  int cyc = 0, checks = 0, fails = 0, mcnt = 0;
  bit in_rst = 1;
  logic [W-1:0] prev_cnt = '0, prev_gray = '0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  // Reference: a step moves the count one place around a ring of MOD values.
  task automatic model_step(input bit d, input int t);
    exp_t e;
    mcnt = (mcnt + (d ? 1 : MOD - 1)) % MOD;
    e.c = mcnt;
    e.w = d ? (mcnt == 0) : (mcnt == MOD - 1);
    e.t = t;
    exp_q.push_back(e);
  endtask
  always @(negedge clk) begin
    if (in_rst) begin
      prev_cnt = count_binary;
      prev_gray = gray_count_out;
    end else begin
      chk("gray_code", int'(gray_count_out), int'(count_binary ^ (count_binary >> 1)));
      if (count_binary != prev_cnt) begin
        if (exp_q.size() == 0) chk("unexpected_update", int'(count_binary), int'(prev_cnt));
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("count", int'(count_binary), e.c);
          chk("wrap", int'(wrap), int'(e.w));
          chk("update_cycle", cyc, e.t);
          chk("gray_one_bit", $countones(gray_count_out ^ prev_gray), 1);
        end
      end else if (wrap) chk("stray_wrap", 1, 0);
      if (done) begin
        if (done_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("done_cycle", cyc, done_q.pop_front());
      end
      prev_cnt = count_binary;
      prev_gray = gray_count_out;
    end
  end
  task automatic run_cmd(input bit d, input int n, input logic [31:0] pm, input logic [31:0] am);
    int rem, i;
    bit ab;
    chk("ready_idle", int'(cmd_ready), 1);
    chk("busy_idle", int'(busy), 0);
    cmd_valid = 1;
    cmd_dir = d;
    cmd_steps = W'(n);
    if (n == 0) done_q.push_back(cyc + 1);
    @(posedge clk);
    @(negedge clk);
    rem = n;
    i = 0;
    ab = 0;
    while (rem > 0 && !ab) begin
      chk("busy_run", int'(busy), 1);
      chk("ready_run", int'(cmd_ready), 0);
      pause = i < 32 ? pm[i] : 1'b0;
      abort = i < 32 ? am[i] : 1'b0;
      cmd_valid = 1'($urandom);
      cmd_dir = 1'($urandom);
      cmd_steps = W'($urandom);
      if (abort) ab = 1;
      else if (!pause) begin
        model_step(d, cyc + 1);
        rem--;
        if (rem == 0) done_q.push_back(cyc + 1);
      end
      @(posedge clk);
      @(negedge clk);
      i++;
    end
    pause = 0;
    if (!ab) begin
      chk("busy_done", int'(busy), 1);
      chk("ready_done", int'(cmd_ready), 0);
      abort = 1'($urandom);
      cmd_valid = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
    end
    abort = 0;
    cmd_valid = 0;
  endtask
  initial begin
    #2;
    chk("rst_count", int'(count_binary), 0);
    chk("rst_gray", int'(gray_count_out), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy_done_wrap", int'({busy, done, wrap}), 0);
    repeat (2) @(negedge clk);
    rst = 0;
    in_rst = 0;
    @(negedge clk);
    run_cmd(1, 5, 0, 0);
    run_cmd(0, 5, 0, 0);
    run_cmd(0, 3, 0, 0);
    run_cmd(1, 4, 32'b1100, 0);
    run_cmd(1, 6, 32'b1000, 32'b1000);
    chk("abort_holds", int'(count_binary), 4);
    run_cmd(1, 2, 0, 0);
    run_cmd(0, 0, 0, 0);
    chk("zero_steps_hold", int'(count_binary), 6);
    // Reset asserted between edges while a command is running.
    cmd_valid = 1;
    cmd_dir = 1;
    cmd_steps = 3'd7;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    for (int k = 0; k < 3; k++) begin
      model_step(1, cyc + 1);
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk);
    #2;
    in_rst = 1;
    rst = 1;
    #1;
    chk("arst_count", int'(count_binary), 0);
    chk("arst_gray", int'(gray_count_out), 0);
    chk("arst_ready", int'(cmd_ready), 1);
    chk("arst_busy_done_wrap", int'({busy, done, wrap}), 0);
    @(negedge clk);
    rst = 0;
    mcnt = 0;
    #1;
    in_rst = 0;
    repeat (5) @(negedge clk);
    chk("post_rst_count", int'(count_binary), 0);
    for (int k = 0; k < 40; k++)
      run_cmd(1'($urandom), int'($urandom_range(0, MOD - 1)), $urandom, $urandom & $urandom & $urandom);
    repeat (3) @(negedge clk);
    chk("pending_updates", exp_q.size(), 0);
    chk("pending_done", done_q.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
